// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for readers, writeback and loader blocks.
// Latency: n/a (types only). Backpressure: n/a.
// Index arithmetic wraps modulo NUM_REGS, which must equal 2**ADDR_W.
package regfile_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    typedef logic [ADDR_W-1:0] idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic idx_t next_idx(input idx_t i);
        return idx_t'((32'(i) + 32'd1) % NUM_REGS);
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream of dumped register words, each tagged with its index and a last flag.
// Latency: n/a (wires only). Backpressure: master holds the word while out_valid & !out_ready.
// Master is the dump reader; slave is the trace buffer or memory writer.
interface regfile_dump_reader_if;
    import regfile_pkg::*;

    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    idx_t  out_idx;
    logic  out_last;

    modport master (output out_valid, output out_data, output out_idx, output out_last,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_idx, input  out_last,
                    output out_ready);

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register-file read-select over an inclusive (wrapping) range and streams each word out.
// Latency: word k valid 2+2k cycles after start is accepted; 1 word per 2 cycles at full rate.
// Backpressure: the captured word is held stable in SEND until out_ready; abort drops it.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  idx_t                  first_idx,
    input  idx_t                  last_idx,
    input  logic                  abort,
    output idx_t                  rd_sel,
    input  data_t                 rd_data,
    regfile_dump_reader_if.master out_if,
    output logic                  busy,
    output logic                  done
);

    state_t state_q, state_d;
    idx_t   cur_q, cur_d;
    idx_t   lst_q, lst_d;
    data_t  data_q, data_d;
    idx_t   oidx_q, oidx_d;
    logic   olast_q, olast_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            lst_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            lst_q   <= lst_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            olast_q <= olast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        lst_d   = lst_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        olast_d = olast_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cur_d   = first_idx;
                    lst_d   = last_idx;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    data_d  = rd_data;
                    oidx_d  = cur_q;
                    olast_d = (cur_q == lst_q);
                    state_d = SEND;
                end
            end
            SEND: begin
                // abort beats a same-cycle handshake: that word is treated as undelivered
                if (abort) begin
                    state_d = IDLE;
                end else if (out_if.out_ready) begin
                    if (olast_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = next_idx(cur_q);
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_sel           = cur_q;
    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = data_q;
    assign out_if.out_idx   = oidx_q;
    assign out_if.out_last  = olast_q;
    assign busy             = (state_q == READ) || (state_q == SEND);
    assign done             = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural 16x32 register file behind rd_sel.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    logic  clk = 1'b0;
    logic  reset, start, abort, busy, done;
    idx_t  first_idx, last_idx, rd_sel;
    data_t rd_data;
    data_t rf [16];
    int    n_cmp = 0;
    int    n_err = 0;

    regfile_dump_reader_if dump_if ();

    regfile_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .abort     (abort),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .out_if    (dump_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    assign rd_data = rf[rd_sel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input idx_t f, input idx_t l);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    // Waits (bounded) for a word, then checks wait latency and fields; caller does the handshake step.
    task automatic expect_word(input idx_t ei, input data_t ed, input logic el);
        int waited = 0;
        while (!dump_if.out_valid && waited < 20) begin
            step();
            waited++;
        end
        chk("word_latency", 32'(waited), 32'd1);
        chk("word_idx",     32'(dump_if.out_idx), 32'(ei));
        chk("word_data",    dump_if.out_data, ed);
        chk("word_last",    32'(dump_if.out_last), 32'(el));
    endtask

    task automatic expect_done();
        chk("done_pulse",   32'(done), 32'd1);
        chk("done_busy",    32'(busy), 32'd0);
        chk("done_valid",   32'(dump_if.out_valid), 32'd0);
        step();
        chk("done_cleared", 32'(done), 32'd0);
        chk("idle_busy",    32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_idx = '0; last_idx = '0;
        dump_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + 32'(i);

        // Reset state
        step(); step();
        reset = 1'b0;
        chk("rst_valid", 32'(dump_if.out_valid), 32'd0);
        chk("rst_data",  dump_if.out_data, 32'd0);
        chk("rst_idx",   32'(dump_if.out_idx), 32'd0);
        chk("rst_last",  32'(dump_if.out_last), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_rdsel", 32'(rd_sel), 32'd0);
        step();

        // Full dump 0..15
        do_start(4'd0, 4'd15);
        for (int i = 0; i < 16; i++) begin
            expect_word(idx_t'(i), 32'hA000_0000 + 32'(i), i == 15);
            step();
        end
        expect_done();

        // Wrapping range 14..1
        do_start(4'd14, 4'd1);
        expect_word(4'd14, 32'hA000_000E, 1'b0); step();
        expect_word(4'd15, 32'hA000_000F, 1'b0); step();
        expect_word(4'd0,  32'hA000_0000, 1'b0); step();
        expect_word(4'd1,  32'hA000_0001, 1'b1); step();
        expect_done();

        // Single word
        rf[7] = 32'hDEAD_BEEF;
        do_start(4'd7, 4'd7);
        expect_word(4'd7, 32'hDEAD_BEEF, 1'b1);
        step();
        expect_done();

        // Backpressure with a register write during the stall
        dump_if.out_ready = 1'b0;
        do_start(4'd2, 4'd4);
        expect_word(4'd2, 32'hA000_0002, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rf[2] = 32'h0000_1234;
            step();
            chk("stall_valid", 32'(dump_if.out_valid), 32'd1);
            chk("stall_idx",   32'(dump_if.out_idx), 32'd2);
            chk("stall_data",  dump_if.out_data, 32'hA000_0002);
        end
        dump_if.out_ready = 1'b1;
        step();
        expect_word(4'd3, 32'hA000_0003, 1'b0); step();
        expect_word(4'd4, 32'hA000_0004, 1'b1); step();
        expect_done();

        // Abort in SEND of idx 3 beats the handshake
        do_start(4'd0, 4'd15);
        expect_word(4'd0, 32'hA000_0000, 1'b0); step();
        expect_word(4'd1, 32'hA000_0001, 1'b0); step();
        expect_word(4'd2, 32'h0000_1234, 1'b0); step();
        expect_word(4'd3, 32'hA000_0003, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(dump_if.out_valid), 32'd0);
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        step();
        chk("abort_done2", 32'(done), 32'd0);
        chk("abort_idle",  32'(busy), 32'd0);
        do_start(4'd5, 4'd6);
        expect_word(4'd5, 32'hA000_0005, 1'b0); step();
        expect_word(4'd6, 32'hA000_0006, 1'b1); step();
        expect_done();

        // Reset during READ of idx 5
        do_start(4'd4, 4'd8);
        expect_word(4'd4, 32'hA000_0004, 1'b0);
        step();
        chk("read5_rdsel", 32'(rd_sel), 32'd5);
        chk("read5_busy",  32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_valid", 32'(dump_if.out_valid), 32'd0);
        chk("mrst_data",  dump_if.out_data, 32'd0);
        chk("mrst_idx",   32'(dump_if.out_idx), 32'd0);
        chk("mrst_last",  32'(dump_if.out_last), 32'd0);
        chk("mrst_busy",  32'(busy), 32'd0);
        chk("mrst_done",  32'(done), 32'd0);
        chk("mrst_rdsel", 32'(rd_sel), 32'd0);
        step();
        chk("mrst_done2",  32'(done), 32'd0);
        chk("mrst_valid2", 32'(dump_if.out_valid), 32'd0);

        // start together with abort in IDLE
        first_idx = 4'd3; last_idx = 4'd3;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        step();
        chk("sa_busy2",  32'(busy), 32'd0);
        chk("sa_valid",  32'(dump_if.out_valid), 32'd0);

        // start while busy is ignored and does not change the range
        do_start(4'd8, 4'd9);
        first_idx = 4'd0; last_idx = 4'd15; start = 1'b1;
        expect_word(4'd8, 32'hA000_0008, 1'b0); step();
        expect_word(4'd9, 32'hA000_0009, 1'b1);
        start = 1'b0;
        step();
        expect_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side initiator for the 16 x 32-bit register file. On a start pulse it walks the register file's read-select over an inclusive index range, one register at a time. It captures each combinational read value and streams it out on a valid/ready interface with its index. It serves as the debug/context-save path, for example to dump architectural state to a trace buffer or memory writer.

Parameters:
ADDR_W, 4, register index width
DATA_W, 32, register data width
NUM_REGS, 16, number of registers (must equal 2**ADDR_W; index arithmetic wraps modulo NUM_REGS)

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
start  in  1  begin a dump; sampled only in IDLE
first_idx  in  ADDR_W  first register index, latched on accepted start
last_idx  in  ADDR_W  last register index (inclusive), latched on accepted start
abort  in  1  terminate the dump; honoured in any non-IDLE state
rd_sel  out  ADDR_W  read-select driven to the register-file mux
rd_data  in  DATA_W  combinational mux output for rd_sel
out_valid  out  1  out_data/out_idx/out_last are valid
out_ready  in  1  consumer accepts the word
out_data  out  DATA_W  captured register value
out_idx  out  ADDR_W  index of out_data
out_last  out  1  word is the final word of the range
busy  out  1  high in READ and SEND
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high.
- Reset values: state=IDLE; rd_sel=0; out_valid=0; out_data=0; out_idx=0; out_last=0; busy=0; done=0; internal cur/last regs=0.
- Reset mid-dump aborts it. No further words are emitted and done does not pulse.
- IDLE:
  - start=1 and abort=0: latch cur<=first_idx, lst<=last_idx, then go to READ.
  - start together with abort: abort wins and the block stays in IDLE.
- READ (one cycle):
  - rd_sel=cur.
  - At the clock edge: out_data<=rd_data, out_idx<=cur, out_last<=(cur==lst). Go to SEND.
  - rd_sel holds cur in all non-IDLE states.
- SEND:
  - out_valid=1. out_data, out_idx and out_last stay stable until the handshake (out_valid & out_ready).
  - Handshake with out_last=1: go to DONE.
  - Handshake otherwise: cur<=(cur+1) mod NUM_REGS, go to READ.
- DONE (one cycle): done=1, busy=0, then go to IDLE.
- start is ignored outside IDLE. A start present in the DONE cycle is not accepted; it must be held or re-issued in IDLE.
- Range and wrap:
  - Word count = ((last_idx - first_idx) mod NUM_REGS) + 1, range 1..16.
  - last_idx < first_idx wraps 15 to 0.
  - first_idx == last_idx emits exactly one word with out_last=1.
  - first=0, last=15 emits all 16 words.
- abort in READ or SEND: next state is IDLE, out_valid drops the next cycle even if the word was not accepted, and done does not pulse.
  - abort has priority over a same-cycle handshake; that word counts as not delivered.
- Timing with out_ready tied high:
  - start accepted at edge 0.
  - READ in cycle 1; word k valid in cycle 2+2k.
  - done in the cycle after the last handshake.
  - Throughput is 1 word per 2 cycles.
- Capture: rd_data is sampled only at the end of READ. Register-file writes during SEND do not alter the held word.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS constants.
  - State enum {IDLE, READ, SEND, DONE}.
  - Index type (ADDR_W bits) and data word type, for reuse by the register file and future writeback/loader blocks.
- No sub-module: a single FSM plus index counter and output register. Expected size is about 150 lines.

Test Plan:
- Full dump: preload R[i]=0xA000_0000+i; start first=0,last=15; out_ready=1 -> 16 words idx 0..15 with matching data; out_last only on idx 15; done pulse one cycle after; busy low afterwards.
- Wrap range: first=14,last=1 -> idx sequence 14,15,0,1 with correct data; out_last on idx 1; 4 handshakes total.
- Single word: first=last=7, R7=0xDEAD_BEEF -> one word 0xDEAD_BEEF, idx 7, out_last=1; done the cycle after the handshake.
- Backpressure: first=2,last=4, out_ready low 5 cycles on the first word -> out_valid held, out_data/out_idx stable; write R2=0x1234 during the stall -> out_data unchanged; then 3 words delivered in order.
- Abort: first=0,last=15, assert abort in SEND of idx 3 with out_ready=1 -> idx 3 not counted, out_valid low next cycle, no done, state IDLE; a new start then dumps correctly.
- Reset and start collisions: reset during READ of idx 5 -> all outputs 0 the next cycle, no done; start+abort together in IDLE -> busy stays 0; start while busy -> ignored, range unchanged.
